// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional feature macro used by the top level: IFQ_STATS_EN.
package ifq_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } ifq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ifq_entry_t;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int unsigned ifq_cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Sequential word address, wrapping at the top of the address space.
  function automatic logic [ADDR_W-1:0] ifq_next_addr(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch storage: circular FIFO of {addr, data} entries.
// Synchronous flush, asynchronous active-low reset; push and pop may
// happen together (also when full, the pop frees the written slot).
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic                        i_flush,
  input  ifq_entry_t                  i_din,
  output ifq_entry_t                  o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [ifq_cnt_w(DEPTH)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = ifq_cnt_w(DEPTH);

  ifq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];

  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Entry storage: written on push, no reset needed (outputs are gated when empty).
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: fetches sequential 64-bit words from memory
// into a small FIFO and hands them to the instruction processor.
// Optional macro IFQ_STATS_EN adds the fetched_cnt handshake counter port.
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]       fetched_cnt
`endif
);

  localparam int unsigned CNT_W = ifq_cnt_w(DEPTH);

  ifq_state_t        r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_fetch_pc;

  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ_next;
  logic              w_room;
  ifq_entry_t        w_din;
  ifq_entry_t        w_dout;

  assign w_pop  = ~w_empty & instr_ready;
  // Full-queue guard is defensive: the FSM never holds a request when full.
  assign w_push = (r_state == REQ) & mem_ack & ~redirect_valid & (~w_full | w_pop);
  assign w_din  = '{addr: r_fetch_pc, data: mem_data_in};

  // Occupancy after this edge, including the same-cycle push and pop.
  assign w_occ_next = {1'b0, w_count} + (CNT_W+1)'(w_push) - (CNT_W+1)'(w_pop);
  assign w_room     = (w_occ_next < (CNT_W+1)'(DEPTH));

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign mem_req      = r_mem_req;
  assign mem_addr_out = r_mem_addr;
  assign instr_valid  = ~w_empty;
  assign instr_data   = w_empty ? '0 : w_dout.data;
  assign instr_addr   = w_empty ? '0 : w_dout.addr;

  // Fetch FSM with registered request outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_ADDR;
      r_fetch_pc <= RESET_ADDR;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_fetch_pc <= redirect_addr;
            r_mem_addr <= redirect_addr;
            r_mem_req  <= 1'b1;
            r_state    <= REQ;
          end else if (w_room) begin
            r_mem_addr <= r_fetch_pc;
            r_mem_req  <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            r_fetch_pc <= redirect_addr;
            if (mem_ack) begin
              r_mem_addr <= redirect_addr;
            end else begin
              // The old request stays on the bus until memory answers it.
              r_state <= DROP;
            end
          end else if (mem_ack) begin
            r_fetch_pc <= ifq_next_addr(r_fetch_pc);
            r_mem_addr <= ifq_next_addr(r_fetch_pc);
            if (!w_room) begin
              r_mem_req <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        DROP: begin
          if (redirect_valid) begin
            r_fetch_pc <= redirect_addr;
          end
          if (mem_ack) begin
            r_mem_addr <= redirect_valid ? redirect_addr : r_fetch_pc;
            r_state    <= REQ;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFQ_STATS_EN
  logic [15:0] r_fetched_cnt;

  // Saturating count of consumer handshakes; redirects do not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetched_cnt <= '0;
    end else if (w_pop && (r_fetched_cnt != '1)) begin
      r_fetched_cnt <= r_fetched_cnt + 16'd1;
    end
  end

  assign fetched_cnt = r_fetched_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue against a transaction-level
// queue model. Build with IFQ_STATS_EN defined to also cover fetched_cnt.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr_out;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_data_in = '0;
  logic        instr_valid;
  logic [63:0] instr_data;
  logic [15:0] instr_addr;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_addr = '0;

  logic        mem_req2;
  logic [15:0] mem_addr_out2;
  logic        mem_ack2 = 1'b0;
  logic [63:0] mem_data_in2 = '0;
  logic        instr_valid2;
  logic [63:0] instr_data2;
  logic [15:0] instr_addr2;
  logic        instr_ready2 = 1'b1;
  logic        redirect_valid2 = 1'b0;
  logic [15:0] redirect_addr2 = '0;
`ifdef IFQ_STATS_EN
  logic [15:0] fetched_cnt;
  logic [15:0] fetched_cnt2;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr_out(mem_addr_out),
    .mem_ack(mem_ack), .mem_data_in(mem_data_in), .instr_valid(instr_valid),
    .instr_data(instr_data), .instr_addr(instr_addr), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr)
`ifdef IFQ_STATS_EN
    , .fetched_cnt(fetched_cnt)
`endif
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr_out(mem_addr_out2),
    .mem_ack(mem_ack2), .mem_data_in(mem_data_in2), .instr_valid(instr_valid2),
    .instr_data(instr_data2), .instr_addr(instr_addr2), .instr_ready(instr_ready2),
    .redirect_valid(redirect_valid2), .redirect_addr(redirect_addr2)
`ifdef IFQ_STATS_EN
    , .fetched_cnt(fetched_cnt2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [79:0] q[$];
  logic [15:0] ep;
  bit          drop;
  bit          fresh;
  bit          prev_hold;
  logic [15:0] prev_addr;
  logic [15:0] cnt_model;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, ~a, a + 16'h1234, a[7:0], a[15:8]};
  endfunction

  task automatic model_reset();
    q.delete();
    ep        = 16'h0000;
    drop      = 1'b0;
    fresh     = 1'b1;
    prev_hold = 1'b0;
    cnt_model = '0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic step(input bit ack, input bit rdy, input bit redir, input logic [15:0] raddr);
    bit          req;
    logic [15:0] a;
    bit          pop;
    req = mem_req;
    a   = mem_addr_out;
    chk("instr_valid", instr_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("head_addr", instr_addr, q[0][79:64]);
      chk("head_data", instr_data, q[0][63:0]);
    end
    if (fresh) chk("req_after_reset", req, 1'b0);
    else       chk("req_iff_room", req, q.size() < DEPTH);
    if (prev_hold) chk("req_hold", {req, a}, {1'b1, prev_addr});
    if (req && !drop) chk("req_addr", a, ep);
`ifdef IFQ_STATS_EN
    chk("fetched_cnt", fetched_cnt, cnt_model);
`endif
    mem_ack        = ack & req;
    mem_data_in    = mem_ack ? mem_word(a) : {$urandom, $urandom};
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_addr  = raddr;
    mem_ack2       = mem_req2;
    mem_data_in2   = mem_word(mem_addr_out2);
    #1;
    pop = (q.size() != 0) && rdy;
    if (pop) begin
      void'(q.pop_front());
      if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
    end
    if (redir) begin
      q.delete();
      drop = req && !ack;
      ep   = raddr;
    end else if (req && ack) begin
      if (drop) drop = 1'b0;
      else begin
        q.push_back({ep, mem_word(ep)});
        ep = ep + 16'd1;
      end
    end
    prev_hold = req && !ack;
    prev_addr = a;
    @(posedge clk);
    #1;
    fresh = 1'b0;
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    mem_ack        = 1'b1;
    mem_ack2       = 1'b1;
    mem_data_in    = {$urandom, $urandom};
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr_out, 16'h0000);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_data", instr_data, 64'h0);
    chk("rst_iaddr", instr_addr, 16'h0000);
    chk("rst_wrap_addr", mem_addr_out2, 16'hFFFE);
`ifdef IFQ_STATS_EN
    chk("rst_fetched_cnt", fetched_cnt, 16'h0000);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack_ignored", {mem_req, instr_valid}, 2'b00);
    reset       = 1'b1;
    mem_ack     = 1'b0;
    mem_ack2    = 1'b0;
    instr_ready = 1'b0;
    model_reset();
  endtask

  initial begin
    int n;
    #2;
    do_reset();

    // Free-running fetch right after reset, both reset addresses
    step(1, 1, 0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", mem_addr_out, 16'(i));
      chk("wrap_addr", mem_addr_out2, 16'(16'hFFFE + i));
      if (i > 0) chk("seq_instr_addr", instr_addr, 16'(i - 1));
      step(1, 1, 0, 16'h0);
    end

    // Back-pressure: exactly DEPTH requests, then one pop reopens fetch
    do_reset();
    step(1, 0, 0, 16'h0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req) n++;
      step(1, 0, 0, 16'h0);
    end
    chk("req_count_full", n, DEPTH);
    chk("idle_when_full", mem_req, 1'b0);
    step(1, 1, 0, 16'h0);
    chk("refill_req", {mem_req, mem_addr_out}, {1'b1, 16'h0004});

    // Redirect during an outstanding request, memory answers late
    step(0, 1, 1, 16'h0100);
    for (int i = 0; i < 2; i++) begin
      chk("drop_old_addr", mem_addr_out, 16'h0004);
      chk("drop_empty", instr_valid, 1'b0);
      step(0, 0, 0, 16'h0);
    end
    step(1, 0, 0, 16'h0);
    chk("redirect_addr", {mem_req, mem_addr_out}, {1'b1, 16'h0100});
    step(1, 1, 0, 16'h0);
    chk("redirect_first", {instr_valid, instr_addr}, {1'b1, 16'h0100});

    // Reset in the middle of a request with two entries queued
    do_reset();
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    chk("two_entries", {instr_valid, mem_req, mem_addr_out}, {2'b11, 16'h0002});
    do_reset();
    step(1, 1, 0, 16'h0);
    chk("restart_addr", {mem_req, mem_addr_out}, {1'b1, 16'h0000});

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      bit          ack, rdy, redir;
      logic [15:0] ra;
      if (i == 1500) begin
        do_reset();
      end
      ack   = ($urandom_range(0, 99) < 55);
      rdy   = ($urandom_range(0, 99) < 60);
      redir = ($urandom_range(0, 99) < 3);
      ra    = $urandom_range(0, 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'($urandom);
      step(ack, rdy, redir, ra);
    end

`ifdef IFQ_STATS_EN
    // Counter saturation after more than 65535 handshakes
    for (int i = 0; i < 70000; i++) step(1, 1, 0, 16'h0);
    chk("fetched_cnt_sat", fetched_cnt, 16'hFFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
